// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO feeding a uart transmitter over a tx_req/tx_ack handshake.
// Occupancy is tracked in count; full/empty derive from it, never from the pointers.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          inclk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          flush,
    input  logic          ovf_clr,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          ovf,
    output logic [7:0]    tx_data,
    output logic          tx_req,
    input  logic          tx_ack
);

    localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StReq, StRelease} state_e;

    state_e          state_q, state_d;
    logic [7:0]      mem_q [DEPTH];
    logic [AW-1:0]   wp_q, wp_d;
    logic [AW-1:0]   rp_q, rp_d;
    logic [AW:0]     count_q, count_d;
    logic            ovf_q, ovf_d;
    logic [7:0]      tx_data_q, tx_data_d;

    logic            do_write;
    logic            drop;
    logic            pop;
    logic            load;

    assign full    = (count_q == FullCount);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign ovf     = ovf_q;
    assign tx_data = tx_data_q;
    assign tx_req  = (state_q == StReq);

    // A dropped write is judged on the registered count, so a same-cycle pop does not rescue it.
    assign do_write = wr_en && !full && !flush && !rst;
    assign drop     = wr_en && full && !flush;
    assign pop      = (state_q == StReq) && tx_ack && !flush;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            StIdle: begin
                if (!empty && !tx_ack) begin
                    load    = 1'b1;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (tx_ack) begin
                    state_d = StRelease;
                end
            end
            StRelease: begin
                // count_q already reflects the pop taken on the REQ -> RELEASE edge.
                if (!tx_ack) begin
                    if (count_q != '0) begin
                        load    = 1'b1;
                        state_d = StReq;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (flush) begin
            load    = 1'b0;
            state_d = StRelease;
        end
    end

    always_comb begin
        wp_d      = wp_q;
        rp_d      = rp_q;
        count_d   = count_q;
        tx_data_d = tx_data_q;
        ovf_d     = ovf_q;

        if (do_write) begin
            wp_d = wp_q + 1'b1;
        end
        if (pop) begin
            rp_d = rp_q + 1'b1;
        end
        case ({do_write, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (flush) begin
            wp_d    = '0;
            rp_d    = '0;
            count_d = '0;
        end

        if (load) begin
            tx_data_d = mem_q[rp_q];
        end

        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge inclk) begin
        if (rst) begin
            state_q   <= StIdle;
            wp_q      <= '0;
            rp_q      <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            tx_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            tx_data_q <= tx_data_d;
        end
    end

    always_ff @(posedge inclk) begin
        if (do_write) begin
            mem_q[wp_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: vector table, directed corner sequences and a
// randomized run against a queue-based model of the FIFO and uart sink.
module tb_uart_tx_fifo;

    logic       inclk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       flush = 1'b0;
    logic       ovf_clr = 1'b0;
    logic       tx_ack = 1'b0;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       ovf;
    logic [7:0] tx_data;
    logic       tx_req;

    int n_vec = 0;
    int n_err = 0;

    uart_tx_fifo #(
        .DEPTH(16),
        .AW   (4)
    ) dut (
        .inclk  (inclk),
        .rst    (rst),
        .wr_en  (wr_en),
        .wr_data(wr_data),
        .flush  (flush),
        .ovf_clr(ovf_clr),
        .full   (full),
        .empty  (empty),
        .count  (count),
        .ovf    (ovf),
        .tx_data(tx_data),
        .tx_req (tx_req),
        .tx_ack (tx_ack)
    );

    always #5 inclk = ~inclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    typedef struct {
        logic       rst;
        logic       wr_en;
        logic [7:0] wr_data;
        logic       flush;
        logic       ovf_clr;
        logic       tx_ack;
        logic       exp_req;
        logic [7:0] exp_data;
        logic [4:0] exp_cnt;
        logic       exp_ovf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic w, logic [7:0] d, logic f, logic c, logic a,
                                logic eq, logic [7:0] ed, logic [4:0] ec, logic eo);
        vec_t v;
        v.rst = r; v.wr_en = w; v.wr_data = d; v.flush = f; v.ovf_clr = c; v.tx_ack = a;
        v.exp_req = eq; v.exp_data = ed; v.exp_cnt = ec; v.exp_ovf = eo;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge inclk);
        #1;
    endtask

    task automatic clear_inputs();
        rst = 1'b0; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0; ovf_clr = 1'b0; tx_ack = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_en = 1'b1;
        wr_data = b;
        step();
        wr_en = 1'b0;
    endtask

    // Bounded wait for tx_req; an expired bound is reported as a failed comparison.
    task automatic wait_req(input string name);
        for (int i = 0; i < 20 && !tx_req; i++) begin
            step();
        end
        check(name, tx_req, 1);
    endtask

    // Randomized-run model state
    logic [7:0] exp_q[$];
    int         wr_n;
    int         rx_n;
    int         delay;
    logic [7:0] got;

    initial begin
        // Columns: rst wr data flush clr ack | req data count ovf
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0,  0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0,  0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 1, 8'h55, 0, 0, 0,  0, 8'h00, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0,  1, 8'h55, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0,  1, 8'h55, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1,  0, 8'h55, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0,  0, 8'h55, 0, 0));
        tbl.push_back(mk(0, 1, 8'hA1, 0, 0, 0,  0, 8'h55, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0,  1, 8'hA1, 1, 0));
        tbl.push_back(mk(0, 1, 8'hB2, 0, 0, 1,  0, 8'hA1, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0,  1, 8'hB2, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1,  0, 8'hB2, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1,  0, 8'hB2, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0,  0, 8'hB2, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 0,  0, 8'hB2, 0, 0));
        tbl.push_back(mk(0, 1, 8'h11, 0, 0, 0,  0, 8'hB2, 1, 0));
        tbl.push_back(mk(0, 1, 8'h22, 0, 0, 0,  1, 8'h11, 2, 0));
        tbl.push_back(mk(0, 1, 8'h33, 1, 0, 0,  0, 8'h11, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1,  0, 8'h11, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0,  0, 8'h11, 0, 0));
        tbl.push_back(mk(0, 1, 8'h44, 0, 0, 0,  0, 8'h11, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0,  1, 8'h44, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1,  0, 8'h44, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0,  0, 8'h44, 0, 0));

        #1;
        foreach (tbl[i]) begin
            rst = tbl[i].rst; wr_en = tbl[i].wr_en; wr_data = tbl[i].wr_data;
            flush = tbl[i].flush; ovf_clr = tbl[i].ovf_clr; tx_ack = tbl[i].tx_ack;
            step();
            check($sformatf("tbl%0d_req", i), tx_req, tbl[i].exp_req);
            check($sformatf("tbl%0d_data", i), tx_data, tbl[i].exp_data);
            check($sformatf("tbl%0d_count", i), count, tbl[i].exp_cnt);
            check($sformatf("tbl%0d_ovf", i), ovf, tbl[i].exp_ovf);
            check($sformatf("tbl%0d_empty", i), empty, tbl[i].exp_cnt == 0);
            check($sformatf("tbl%0d_full", i), full, tbl[i].exp_cnt == 16);
        end
        clear_inputs();

        // Fill to full, overflow, then drain in order
        do_reset();
        for (int i = 0; i < 16; i++) begin
            write_byte(8'(i));
        end
        check("fill_full", full, 1);
        check("fill_count", count, 16);
        check("fill_ovf", ovf, 0);
        write_byte(8'hAA);
        check("ovf_set", ovf, 1);
        check("ovf_count", count, 16);
        for (int i = 0; i < 16; i++) begin
            wait_req($sformatf("drain%0d_req", i));
            check($sformatf("drain%0d_data", i), tx_data, i);
            tx_ack = 1'b1;
            step();
            tx_ack = 1'b0;
            step();
        end
        repeat (5) step();
        check("drain_no_extra_req", tx_req, 0);
        check("drain_empty", empty, 1);
        check("drain_ovf_sticky", ovf, 1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("ovf_clr", ovf, 0);

        // Long ack: exactly one pop, next request only after ack falls
        do_reset();
        write_byte(8'h5A);
        write_byte(8'h6B);
        wait_req("long_ack_req");
        check("long_ack_data0", tx_data, 8'h5A);
        tx_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("long_ack%0d_req", i), tx_req, 0);
            check($sformatf("long_ack%0d_count", i), count, 1);
        end
        tx_ack = 1'b0;
        step();
        check("long_ack_rereq", tx_req, 1);
        check("long_ack_data1", tx_data, 8'h6B);
        tx_ack = 1'b1;
        step();
        tx_ack = 1'b0;
        step();
        check("long_ack_final_count", count, 0);
        check("long_ack_final_req", tx_req, 0);

        // Reset while a byte is in flight
        do_reset();
        write_byte(8'h01);
        write_byte(8'h02);
        write_byte(8'h03);
        wait_req("rst_flight_req");
        check("rst_flight_count", count, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_req", tx_req, 0);
        check("rst_data", tx_data, 8'h00);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_ovf", ovf, 0);
        tx_ack = 1'b1;
        step();
        tx_ack = 1'b0;
        step();
        check("rst_late_ack_count", count, 0);
        check("rst_late_ack_req", tx_req, 0);

        // Randomized stream with stalling writer and random ack delays
        do_reset();
        exp_q.delete();
        wr_n = 0;
        rx_n = 0;
        delay = $urandom_range(0, 7);
        for (int cyc = 0; cyc < 3000 && rx_n < 40; cyc++) begin
            wr_en = 1'b0;
            if (wr_n < 40 && !full && ($urandom_range(0, 3) != 0)) begin
                wr_en = 1'b1;
                wr_data = 8'(wr_n + 8'h30);
                exp_q.push_back(wr_data);
                wr_n++;
            end
            if (tx_ack) begin
                tx_ack = 1'b0;
            end else if (tx_req) begin
                if (delay == 0) begin
                    tx_ack = 1'b1;
                    got = tx_data;
                    if (exp_q.size() == 0) begin
                        check("rand_unexpected_byte", got, 8'hxx);
                    end else begin
                        check($sformatf("rand_byte%0d", rx_n), got, exp_q.pop_front());
                    end
                    rx_n++;
                    delay = $urandom_range(0, 7);
                end else begin
                    delay--;
                end
            end
            step();
            check("rand_count", count, wr_n - rx_n);
        end
        clear_inputs();
        step();
        check("rand_all_received", rx_n, 40);
        check("rand_ovf", ovf, 0);
        check("rand_empty", empty, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
